regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
Parametrised next-generation CPU register file: 2 combinational read ports, 2 write ports, optional write-to-read bypass, and a per-register busy scoreboard. The scoreboard tracks outstanding writebacks for the pipelined core. It sits between decode/issue (read, issue) and writeback (write ports A/B). Register 0 is optionally hardwired to zero.

Parameters:
DATA_W  32  register width in bits
ADDR_W  5  address width; depth = 2**ADDR_W registers
ZERO_REG  1  1: register 0 reads 0, ignores writes and never becomes busy
BYPASS  1  1: same-cycle write data is forwarded to read ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
raddr1  in  ADDR_W  read port 1 address
raddr2  in  ADDR_W  read port 2 address
rdata1  out  DATA_W  read port 1 data (combinational)
rdata2  out  DATA_W  read port 2 data (combinational)
rbusy1  out  1  register at raddr1 has a pending write
rbusy2  out  1  register at raddr2 has a pending write
wea  in  1  write enable, port A
waddra  in  ADDR_W  write address, port A
wdataa  in  DATA_W  write data, port A
web  in  1  write enable, port B
waddrb  in  ADDR_W  write address, port B
wdatab  in  DATA_W  write data, port B
issue_en  in  1  mark issue_addr busy (new producer issued)
issue_addr  in  ADDR_W  destination register of the issued instruction
busy_cnt  out  ADDR_W+1  number of busy registers

Behaviour:
- Reset (async, rst=1): all registers = 0; all busy bits = 0; busy_cnt = 0. rdata = 0 and rbusy = 0 while rst is held. Reset is effective mid-cycle and overrides any write or issue on the same edge.
- Write: on posedge, if wea, then reg[waddra] <= wdataa. If web, then reg[waddrb] <= wdatab.
- Write collision: wea and web both set with waddra == waddrb -> port B wins.
- Zero register: with ZERO_REG=1, writes to address 0 are dropped. With ZERO_REG=0, register 0 is an ordinary register.
- Read: rdataN = reg[raddrN], combinational, 0-cycle latency. With ZERO_REG=1, raddrN==0 -> rdataN = 0 regardless of bypass.
- Bypass (BYPASS=1): if web and waddrb==raddrN, rdataN = wdatab. Otherwise, if wea and waddra==raddrN, rdataN = wdataa. Otherwise rdataN = the stored value. Writes to address 0 are never forwarded when ZERO_REG=1.
- Bypass off (BYPASS=0): new data is visible on reads the cycle after the write edge.
- Scoreboard, on each posedge, for every register i:
  - set_i = issue_en & issue_addr==i
  - clr_i = (wea & waddra==i) | (web & waddrb==i)
  - busy[i] <= set_i ? 1 : (clr_i ? 0 : busy[i])
  - Issue has priority over a same-cycle writeback to the same register (the new producer is still outstanding).
  - ZERO_REG=1: busy[0] is held at 0.
- rbusyN:
  - BYPASS=1: busy[raddrN] & ~clr_raddrN, i.e. a register written this cycle reads as not busy.
  - BYPASS=0: busy[raddrN].
  - A same-cycle issue does not affect rbusy until the next cycle.
- busy_cnt = popcount of the busy vector, registered state only. Range 0..2**ADDR_W, with (2**ADDR_W)-1 maximum when ZERO_REG=1.
- Re-issue to an already busy register leaves it busy; busy_cnt is unchanged.
- A write to a non-busy register updates data only; no error.

Test Plan:
- Reset: preload reg5=0x1234 and busy5, then pulse rst asynchronously between edges -> rdata1(raddr1=5) = 0, rbusy1 = 0, and busy_cnt = 0 immediately.
- Dual write collision: wea/web both at addr 7 with 0xAAAA0000 / 0x5555FFFF -> next cycle reg7 = 0x5555FFFF. Same cycle with BYPASS=1 -> rdata1 (raddr1=7) = 0x5555FFFF.
- Zero register: write 0xDEADBEEF to addr 0 and issue_addr=0 -> rdata=0, rbusy=0, busy_cnt unchanged. Repeat with ZERO_REG=0 -> reads 0xDEADBEEF next cycle.
- Scoreboard: issue 3, 4, 9 on consecutive cycles -> busy_cnt 1, 2, 3. Write port A to reg 4 with 0x44 -> rbusy on addr 4 = 0 same cycle (BYPASS=1), busy_cnt = 2 next cycle.
- Issue/writeback race: issue_en at addr 6 while web writes 0x66 to addr 6 -> reg6=0x66, busy6 stays 1, busy_cnt +1.
- BYPASS=0 build: write 0x77 to reg 2 with raddr1=2 -> rdata1 shows old value 0 that cycle and 0x77 the next; rbusy1 clears only after the edge.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: 2R/2W register file with write-to-read bypass and per-register busy scoreboard
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit ZERO_REG = 1,
  parameter bit BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy1,
  output logic              rbusy2,
  input  logic              wea,
  input  logic [ADDR_W-1:0] waddra,
  input  logic [DATA_W-1:0] wdataa,
  input  logic              web,
  input  logic [ADDR_W-1:0] waddrb,
  input  logic [DATA_W-1:0] wdatab,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wa_ok, wb_ok, is_ok;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic              rb [2];
  assign ra[0] = raddr1;
  assign ra[1] = raddr2;
  assign rdata1 = rd[0];
  assign rdata2 = rd[1];
  assign rbusy1 = rb[0];
  assign rbusy2 = rb[1];
  // Accesses to a hardwired zero register are dropped before they reach data, bypass or scoreboard.
  assign wa_ok = wea & ~(ZERO_REG && waddra == '0);
  assign wb_ok = web & ~(ZERO_REG && waddrb == '0);
  assign is_ok = issue_en & ~(ZERO_REG && issue_addr == '0);
  always_comb begin
    regs_d = regs_q;
    if (wa_ok) regs_d[waddra] = wdataa;
    if (wb_ok) regs_d[waddrb] = wdatab;
    busy_d = busy_q;
    if (wa_ok) busy_d[waddra] = 1'b0;
    if (wb_ok) busy_d[waddrb] = 1'b0;
    if (is_ok) busy_d[issue_addr] = 1'b1;
  end
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = (rst || (ZERO_REG && ra[p] == '0)) ? '0 :
              (BYPASS && wb_ok && waddrb == ra[p]) ? wdatab :
              (BYPASS && wa_ok && waddra == ra[p]) ? wdataa : regs_q[ra[p]];
      rb[p] = ~rst & busy_q[ra[p]] &
              ~(BYPASS && ((wa_ok && waddra == ra[p]) || (wb_ok && waddrb == ra[p])));
    end
  end
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < DEPTH; i++) busy_cnt = busy_cnt + (ADDR_W+1)'(busy_q[i]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
endmodule
